// File: rtl/audio_pkg.sv
// Shared audio definitions: waveform encodings, note-entry layout, sequencer states.
// Latency: n/a (types, constants and a table-building helper only).
// Backpressure: n/a.
package audio_pkg;

   typedef enum logic [1:0] {
      FORM_SIN    = 2'd0,
      FORM_TRI    = 2'd1,
      FORM_SQ     = 2'd2,
      FORM_SILENT = 2'd3
   } form_e;

   // Note entry: [8] rest, [7:3] freq_id, [2:0] dur (note lasts dur+1 beats)
   localparam int ENTRY_W  = 9;
   localparam int REST_BIT = 8;
   localparam int ID_MSB   = 7;
   localparam int ID_LSB   = 3;
   localparam int DUR_MSB  = 2;
   localparam int DUR_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2
   } seq_state_e;

   function automatic logic [ENTRY_W-1:0] note_entry(input logic rest,
                                                     input logic [4:0] id,
                                                     input logic [2:0] dur);
      return {rest, id, dur};
   endfunction

endpackage

// File: rtl/melody_rom.sv
// Fixed note table, combinational lookup of one 9-bit entry per address.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; addresses at or beyond LEN read as a silent 1-beat rest.
// Ports: i_addr (ADDR_W) table address in; o_entry (9) {rest, freq_id, dur} out.
module melody_rom
   import audio_pkg::*;
#(
   parameter int LEN    = 16,
   parameter int ADDR_W = 4
)(
   input  logic [ADDR_W-1:0]  i_addr,
   output logic [ENTRY_W-1:0] o_entry
);

   always_comb begin
      o_entry = note_entry(1'b1, 5'd0, 3'd0);
      if (int'(i_addr) < LEN) begin
         case (int'(i_addr))
            0:       o_entry = note_entry(1'b0, 5'd12, 3'd1);
            1:       o_entry = note_entry(1'b1, 5'd0,  3'd0);
            2:       o_entry = note_entry(1'b0, 5'd7,  3'd0);
            3:       o_entry = note_entry(1'b0, 5'd9,  3'd1);
            4:       o_entry = note_entry(1'b0, 5'd11, 3'd0);
            5:       o_entry = note_entry(1'b0, 5'd12, 3'd3);
            6:       o_entry = note_entry(1'b1, 5'd0,  3'd1);
            7:       o_entry = note_entry(1'b0, 5'd14, 3'd0);
            8:       o_entry = note_entry(1'b0, 5'd16, 3'd0);
            9:       o_entry = note_entry(1'b0, 5'd17, 3'd1);
            10:      o_entry = note_entry(1'b0, 5'd16, 3'd0);
            11:      o_entry = note_entry(1'b0, 5'd14, 3'd0);
            12:      o_entry = note_entry(1'b0, 5'd12, 3'd3);
            13:      o_entry = note_entry(1'b1, 5'd0,  3'd0);
            14:      o_entry = note_entry(1'b0, 5'd7,  3'd1);
            15:      o_entry = note_entry(1'b0, 5'd12, 3'd7);
            default: o_entry = note_entry(1'b1, 5'd0,  3'd0);
         endcase
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Plays the note table by driving the tone generator's freq_id/new_f/form controls.
// Latency: start pulse -> first new_f in 2 cycles; each note occupies 1 LOAD + (dur+1)*TICKS_PER_BEAT PLAY cycles.
// Backpressure: none; stop (priority over start) silences on the next cycle, start outside IDLE is ignored.
// Ports: i_clock, i_reset (sync, active high), i_start/i_stop pulses, i_loop level, i_form_sel;
//        o_freq_id, o_new_f pulse, o_form, o_playing, o_note_addr, o_done pulse (all registered).
module melody_sequencer
   import audio_pkg::*;
#(
   parameter int TICKS_PER_BEAT = 8125000,
   parameter int LEN            = 16,
   parameter int ADDR_W         = 4
)(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_loop,
   input  logic [1:0]        i_form_sel,
   output logic [4:0]        o_freq_id,
   output logic              o_new_f,
   output logic [1:0]        o_form,
   output logic              o_playing,
   output logic [ADDR_W-1:0] o_note_addr,
   output logic              o_done
);

   localparam int                TW        = $clog2(TICKS_PER_BEAT);
   localparam logic [TW-1:0]     TICK_MAX  = TW'(TICKS_PER_BEAT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

   seq_state_e        r_state, w_state_nxt;
   logic [TW-1:0]     r_tick_cnt, w_tick_cnt_nxt;
   logic [2:0]        r_beat_cnt, w_beat_cnt_nxt;
   logic [4:0]        r_freq_id, w_freq_id_nxt;
   logic              r_new_f, w_new_f_nxt;
   logic [1:0]        r_form, w_form_nxt;
   logic              r_playing, w_playing_nxt;
   logic [ADDR_W-1:0] r_note_addr, w_note_addr_nxt;
   logic              r_done, w_done_nxt;

   logic [ENTRY_W-1:0] w_entry;
   logic               w_tick_zero;
   logic               w_beat_zero;
   logic               w_note_end;
   logic               w_last_note;

   melody_rom #(
      .LEN    (LEN),
      .ADDR_W (ADDR_W)
   ) u_rom (
      .i_addr  (r_note_addr),
      .o_entry (w_entry)
   );

   assign w_tick_zero = (r_tick_cnt == '0);
   assign w_beat_zero = (r_beat_cnt == 3'd0);
   assign w_note_end  = (r_state == ST_PLAY) && w_tick_zero && w_beat_zero;
   assign w_last_note = (r_note_addr == LAST_ADDR);

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (i_stop) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_PLAY;
            ST_PLAY: if (w_note_end) w_state_nxt = (!w_last_note || i_loop) ? ST_LOAD : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output and counter next values; everything is registered below
   always_comb begin
      w_tick_cnt_nxt  = r_tick_cnt;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_freq_id_nxt   = r_freq_id;
      w_new_f_nxt     = 1'b0;
      w_form_nxt      = r_form;
      w_playing_nxt   = r_playing;
      w_note_addr_nxt = r_note_addr;
      w_done_nxt      = 1'b0;
      if (i_stop) begin
         w_form_nxt      = FORM_SILENT;
         w_playing_nxt   = 1'b0;
         w_note_addr_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  w_note_addr_nxt = '0;
                  w_playing_nxt   = 1'b1;
               end
            end
            ST_LOAD: begin
               // Rests keep the last freq_id so the generator is not retriggered
               if (w_entry[REST_BIT]) begin
                  w_form_nxt = FORM_SILENT;
               end else begin
                  w_freq_id_nxt = w_entry[ID_MSB:ID_LSB];
                  w_form_nxt    = i_form_sel;
                  w_new_f_nxt   = 1'b1;
               end
               w_beat_cnt_nxt = w_entry[DUR_MSB:DUR_LSB];
               w_tick_cnt_nxt = TICK_MAX;
            end
            ST_PLAY: begin
               if (!w_tick_zero) begin
                  w_tick_cnt_nxt = r_tick_cnt - 1'b1;
               end else if (!w_beat_zero) begin
                  w_beat_cnt_nxt = r_beat_cnt - 3'd1;
                  w_tick_cnt_nxt = TICK_MAX;
               end else if (!w_last_note) begin
                  w_note_addr_nxt = r_note_addr + 1'b1;
               end else if (i_loop) begin
                  w_note_addr_nxt = '0;
               end else begin
                  w_done_nxt      = 1'b1;
                  w_form_nxt      = FORM_SILENT;
                  w_playing_nxt   = 1'b0;
                  w_note_addr_nxt = '0;
               end
            end
            default: begin
               w_form_nxt    = FORM_SILENT;
               w_playing_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_tick_cnt  <= '0;
         r_beat_cnt  <= 3'd0;
         r_freq_id   <= 5'd0;
         r_new_f     <= 1'b0;
         r_form      <= FORM_SILENT;
         r_playing   <= 1'b0;
         r_note_addr <= '0;
         r_done      <= 1'b0;
      end else begin
         r_tick_cnt  <= w_tick_cnt_nxt;
         r_beat_cnt  <= w_beat_cnt_nxt;
         r_freq_id   <= w_freq_id_nxt;
         r_new_f     <= w_new_f_nxt;
         r_form      <= w_form_nxt;
         r_playing   <= w_playing_nxt;
         r_note_addr <= w_note_addr_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign o_freq_id   = r_freq_id;
   assign o_new_f     = r_new_f;
   assign o_form      = r_form;
   assign o_playing   = r_playing;
   assign o_note_addr = r_note_addr;
   assign o_done      = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with a 3-entry table and 4 ticks per beat.
// Expected new_f / done events are queued when start is driven and matched by a monitor.
// Cycle-specific output levels are checked inline.
module tb_melody_sequencer;

   localparam int TPB    = 4;
   localparam int LEN    = 3;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              loop_en = 1'b0;
   logic [1:0]        form_sel = 2'd0;
   logic [4:0]        freq_id;
   logic              new_f;
   logic [1:0]        form;
   logic              playing;
   logic [ADDR_W-1:0] note_addr;
   logic              done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic mon_en = 1'b0;

   typedef struct {
      int cyc;
      int id;
      int form;
   } nf_ev_t;

   nf_ev_t exp_nf[$];
   int     exp_done[$];

   melody_sequencer #(
      .TICKS_PER_BEAT (TPB),
      .LEN            (LEN),
      .ADDR_W         (ADDR_W)
   ) dut (
      .i_clock     (clk),
      .i_reset     (reset),
      .i_start     (start),
      .i_stop      (stop),
      .i_loop      (loop_en),
      .i_form_sel  (form_sel),
      .o_freq_id   (freq_id),
      .o_new_f     (new_f),
      .o_form      (form),
      .o_playing   (playing),
      .o_note_addr (note_addr),
      .o_done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_form"}, form, 3);
      check_val({tag, "_playing"}, playing, 0);
      check_val({tag, "_addr"}, note_addr, 0);
      check_val({tag, "_new_f"}, new_f, 0);
   endtask

   // Event monitor: every new_f / done pulse must match the head of its queue
   always @(negedge clk) begin
      if (mon_en) begin
         if (new_f === 1'b1) begin
            if (exp_nf.size() == 0) begin
               check_val("nf_unexpected", new_f, 0);
            end else begin
               nf_ev_t e;
               e = exp_nf.pop_front();
               check_val("nf_cycle", cyc, e.cyc);
               check_val("nf_freq_id", freq_id, e.id);
               check_val("nf_form", form, e.form);
            end
         end
         if (done === 1'b1) begin
            if (exp_done.size() == 0) begin
               check_val("done_unexpected", done, 0);
            end else begin
               int dc;
               dc = exp_done.pop_front();
               check_val("done_cycle", cyc, dc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      // Reset values
      reset = 1'b1;
      repeat (3) step();
      check_val("rst_freq_id", freq_id, 0);
      check_val("rst_new_f", new_f, 0);
      check_val("rst_form", form, 3);
      check_val("rst_playing", playing, 0);
      check_val("rst_addr", note_addr, 0);
      check_val("rst_done", done, 0);
      reset = 1'b0;
      mon_en = 1'b1;
      step();

      // Full pass with loop=0; a start pulse during PLAY must change nothing
      t = cyc;
      exp_nf.push_back('{t + 2, 12, 0});
      exp_nf.push_back('{t + 16, 7, 0});
      exp_done.push_back(t + 20);
      pulse_start();
      check_val("s1_load_playing", playing, 1);
      check_val("s1_load_addr", note_addr, 0);
      wait_until(t + 4);
      pulse_start();
      wait_until(t + 10);
      check_val("s1_addr_entry1", note_addr, 1);
      wait_until(t + 11);
      check_val("s2_rest_form", form, 3);
      wait_until(t + 15);
      check_val("s2_addr_entry2", note_addr, 2);
      wait_until(t + 20);
      check_val("s2_done", done, 1);
      check_val("s2_done_playing", playing, 0);
      check_val("s2_done_addr", note_addr, 0);
      check_val("s2_done_form", form, 3);
      wait_until(t + 21);
      check_val("s2_done_pulse_end", done, 0);

      // Loop across the last entry, then stop mid-note of entry 0
      loop_en = 1'b1;
      t = cyc;
      exp_nf.push_back('{t + 2, 12, 0});
      exp_nf.push_back('{t + 16, 7, 0});
      exp_nf.push_back('{t + 21, 12, 0});
      pulse_start();
      wait_until(t + 20);
      check_val("s3_wrap_addr", note_addr, 0);
      check_val("s3_wrap_playing", playing, 1);
      wait_until(t + 24);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_idle("s4_stop");
      repeat (5) step();
      check_val("s4_stop_hold_playing", playing, 0);
      loop_en = 1'b0;

      // Replay after stop; form_sel change mid-note reaches only the next note
      t = cyc;
      exp_nf.push_back('{t + 2, 12, 0});
      exp_nf.push_back('{t + 16, 7, 2});
      exp_done.push_back(t + 20);
      pulse_start();
      wait_until(t + 4);
      form_sel = 2'd2;
      wait_until(t + 5);
      check_val("s6_form_held", form, 0);
      wait_until(t + 11);
      check_val("s6_rest_form", form, 3);
      wait_until(t + 21);
      check_idle("s6_end");

      // start and stop together in IDLE
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      check_idle("s5_both");
      repeat (4) step();
      check_val("s5_still_idle", playing, 0);

      // Reset during PLAY
      form_sel = 2'd1;
      t = cyc;
      exp_nf.push_back('{t + 2, 12, 1});
      pulse_start();
      wait_until(t + 5);
      check_val("s6_pre_rst_freq", freq_id, 12);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_val("s6_rst_freq_id", freq_id, 0);
      check_val("s6_rst_new_f", new_f, 0);
      check_val("s6_rst_form", form, 3);
      check_val("s6_rst_playing", playing, 0);
      check_val("s6_rst_addr", note_addr, 0);
      check_val("s6_rst_done", done, 0);
      repeat (12) step();
      check_val("s6_post_rst_playing", playing, 0);

      check_val("nf_pending", exp_nf.size(), 0);
      check_val("done_pending", exp_done.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
